alu_op_driver: RTL

- Initiator-side driver for the ALU operand interface (OPA/OPB/CMD/MODE/CIN/CE/INP_VALID).
- Accepts one complete ALU request per valid/ready handshake and issues it under the split-operand protocol that the ALU and its assertion checker enforce.
- Waits the command-dependent result latency, captures RES and flags, and returns them as a one-cycle response pulse.
- Sits between the bench sequencer (or an on-chip command source) and the ALU.

---
 rtl/alu_op_driver.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/alu_op_driver.sv
// alu_op_driver: accepts one ALU request per valid/ready handshake, issues it under the split-operand
// protocol, waits the command latency and returns RES/flags as a one-cycle response pulse.
// Optional feature macro: ALU_OP_DRIVER_CE_IDLE_EN (CE held low while idle with no request).

module alu_op_driver #(
    parameter int WIDTH    = 8,
    parameter int C_WIDTH  = 4,
    parameter int NORM_LAT = 1,
    parameter int MUL_LAT  = 2
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [WIDTH-1:0]   req_opa,
    input  logic [WIDTH-1:0]   req_opb,
    input  logic [C_WIDTH-1:0] req_cmd,
    input  logic               req_mode,
    input  logic               req_cin,
    input  logic [1:0]         req_split,
    input  logic [3:0]         req_gap,
    output logic [WIDTH-1:0]   OPA,
    output logic [WIDTH-1:0]   OPB,
    output logic [C_WIDTH-1:0] CMD,
    output logic               MODE,
    output logic               CIN,
    output logic               CE,
    output logic [1:0]         INP_VALID,
    input  logic [WIDTH:0]     RES,
    input  logic               COUT,
    input  logic               OFLOW,
    input  logic               G,
    input  logic               L,
    input  logic               E,
    input  logic               ERR,
    output logic               rsp_valid,
    output logic [WIDTH:0]     rsp_res,
    output logic [5:0]         rsp_flags
);

    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        PART,
        FULL,
        WAIT,
        RESP
    } state_t;

    state_t               state_q;
    logic                 req_ready_q;
    logic                 ce_q;
    logic [WIDTH-1:0]     opa_q;
    logic [WIDTH-1:0]     opb_q;
    logic [C_WIDTH-1:0]   cmd_q;
    logic                 mode_q;
    logic                 cin_q;
    logic [1:0]           inp_valid_q;
    logic                 rsp_valid_q;
    logic [WIDTH:0]       rsp_res_q;
    logic [5:0]           rsp_flags_q;
    logic [WIDTH-1:0]     lopa_q;
    logic [WIDTH-1:0]     lopb_q;
    logic                 mul_q;
    logic [CNT_W-1:0]     cnt_q;

    logic        req_single;
    logic        req_mul;
    logic        req_psplit;
    logic [1:0]  req_fiv;
    logic [31:0] cmd_u;
    logic        accept;

    // Request classification: operand count, multiply latency and full-issue qualifier.
    always_comb begin
        cmd_u      = 32'(req_cmd);
        req_single = req_mode ? (cmd_u >= 32'd4 && cmd_u <= 32'd7)
                              : (cmd_u >= 32'd6 && cmd_u <= 32'd11);
        req_mul    = req_mode && (cmd_u == 32'd9 || cmd_u == 32'd10);
        req_psplit = !req_single && (req_split == 2'b01 || req_split == 2'b10);
        if (!req_single) begin
            req_fiv = 2'b11;
        end else if (req_split == 2'b01 || req_split == 2'b10) begin
            req_fiv = req_split;
        end else begin
            req_fiv = 2'b01;
        end
    end

    assign accept = (state_q == IDLE) && req_ready_q && req_valid;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            ce_q        <= 1'b0;
            opa_q       <= '0;
            opb_q       <= '0;
            cmd_q       <= '0;
            mode_q      <= 1'b0;
            cin_q       <= 1'b0;
            inp_valid_q <= 2'b00;
            rsp_valid_q <= 1'b0;
            rsp_res_q   <= '0;
            rsp_flags_q <= '0;
            lopa_q      <= '0;
            lopb_q      <= '0;
            mul_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
`ifdef ALU_OP_DRIVER_CE_IDLE_EN
                    ce_q        <= 1'b0;
`else
                    ce_q        <= 1'b1;
`endif
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        ce_q        <= 1'b1;
                        lopa_q      <= req_opa;
                        lopb_q      <= req_opb;
                        mul_q       <= req_mul;
                        cmd_q       <= req_cmd;
                        mode_q      <= req_mode;
                        cin_q       <= req_cin;
                        if (req_psplit) begin
                            state_q     <= PART;
                            cnt_q       <= CNT_W'(req_gap);
                            inp_valid_q <= req_split;
                            opa_q       <= req_split[0] ? req_opa : '0;
                            opb_q       <= req_split[1] ? req_opb : '0;
                        end else begin
                            state_q     <= FULL;
                            inp_valid_q <= req_fiv;
                            opa_q       <= req_fiv[0] ? req_opa : '0;
                            opb_q       <= req_fiv[1] ? req_opb : '0;
                        end
                    end
                end
                PART: begin
                    if (cnt_q == '0) begin
                        state_q     <= FULL;
                        inp_valid_q <= 2'b11;
                        opa_q       <= lopa_q;
                        opb_q       <= lopb_q;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                FULL: begin
                    state_q     <= WAIT;
                    inp_valid_q <= 2'b00;
                    cnt_q       <= mul_q ? CNT_W'(MUL_LAT - 1) : CNT_W'(NORM_LAT - 1);
                end
                WAIT: begin
                    // Operands and command stay on the bus until the result is sampled.
                    if (cnt_q == '0) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_res_q   <= RES;
                        rsp_flags_q <= {COUT, OFLOW, G, L, E, ERR};
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
`ifdef ALU_OP_DRIVER_CE_IDLE_EN
                    ce_q        <= 1'b0;
`endif
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign OPA       = opa_q;
    assign OPB       = opb_q;
    assign CMD       = cmd_q;
    assign MODE      = mode_q;
    assign CIN       = cin_q;
    assign CE        = ce_q;
    assign INP_VALID = inp_valid_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_res   = rsp_res_q;
    assign rsp_flags = rsp_flags_q;

endmodule
